id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   Decode-to-execute pipeline register for the MIPS core. It sits directly
//   downstream of the decode controller and captures the control bundle, operands
//   and register specifiers each cycle. It detects load-use hazards and inserts
//   one bubble, honours branch/jump flushes and back-pressure from EX, and counts
//   load-use bubbles for performance analysis.
// PARAMETERS
//   DATA_W   32   datapath width (pc+4, register operands, sign-extended imm)
//   CNT_W    16   width of saturating load-use bubble counter
// PORTS
//   clk         in   1       core clock, rising edge
//   rst         in   1       asynchronous, active-high reset
//   id_valid    in   1       ID slot holds a real instruction
//   id_ctrl     in   14      packed {RegDst[1:0],Jmp[1:0],DataC,Regwrite,AluSrc,
//                            Branch,MemRead,MemWrite,MemtoReg,AluOperation[2:0]}
//   id_pc4      in   DATA_W  pc+4 of ID instruction
//   id_rd1      in   DATA_W  register-file read data, rs
//   id_rd2      in   DATA_W  register-file read data, rt
//   id_imm      in   DATA_W  sign-extended immediate
//   id_rs       in   5       rs specifier
//   id_rt       in   5       rt specifier
//   id_rd       in   5       rd specifier
//   flush       in   1       branch/jump resolved taken in EX; kill ID instruction
//   ex_stall    in   1       EX/MEM not ready; hold EX register
//   id_stall    out  1       IF/ID and PC must hold this cycle (combinational)
//   ex_valid    out  1       EX slot holds a real instruction
//   ex_ctrl     out  14      registered control bundle, same packing as id_ctrl
//   ex_pc4 / ex_rd1 / ex_rd2 / ex_imm   out  DATA_W  registered operands
//   ex_rs / ex_rt / ex_rd               out  5       registered specifiers
//   bubble_cnt  out  CNT_W   saturating count of load-use bubbles
// BEHAVIOUR
//   - Reset (async, immediate): all registered outputs 0, pend_flush 0.
//     bubble_cnt is 0 and id_stall = ex_stall, because ex_valid is 0.
//   - Latency: one cycle from ID inputs to EX outputs.
//   - Bubble: ex_valid=0, ex_ctrl=0 and all data/specifiers 0. This guarantees
//     no Regwrite, MemWrite, Branch or Jmp.
//   - lu_hazard = ex_valid & ex_ctrl.MemRead & id_valid & (ex_rt != 0) &
//     (ex_rt == id_rs | ex_rt == id_rt).
//   - id_stall = ex_stall | (lu_hazard & ~flush & ~pend_flush).
//   - Per rising edge, first match wins:
//       1. ex_stall=1: EX holds all values; pend_flush <= pend_flush | flush.
//       2. flush | pend_flush: load bubble; pend_flush <= 0; no count.
//       3. lu_hazard: load bubble; bubble_cnt += 1, saturating at all-ones.
//       4. Otherwise: load ID values, ex_valid <= id_valid.
//          ex_ctrl <= id_valid ? id_ctrl : 0.
//   - A flush raised while stalled is never lost; it applies on the first
//     non-stalled edge.
//   - A load-use hazard stalls exactly one cycle. The bubble clears ex_valid,
//     which clears the hazard.
//   - Reset asserted mid-stall or mid-hazard discards the in-flight instruction
//     and any pending flush.
// STRUCTURE
//   - Shared package cpu_pkg holds CTRL_W=14, localparam bit indices for each
//     control field (CTRL_MEMREAD, CTRL_REGWRITE, ...), and REG_ZERO=5'd0.
//   - One sub-module: lu_hazard_detect, combinational, producing lu_hazard from
//     the ex_* and id_* fields.
//   - The registers, pend_flush and the counter live in id_ex_stage.
// TESTING
//   1. Normal load: id_valid=1, addi ctrl (Regwrite=1, AluSrc=1, AluOp=010),
//      rd1=5, imm=3 -> next edge: ex_valid=1, ex_ctrl/ex_rd1/ex_imm match,
//      id_stall=0.
//   2. Load-use: EX holds lw rt=8; ID add rs=8 -> id_stall=1 that cycle.
//      Next edge: ex_valid=0, ex_ctrl=0, bubble_cnt=1. Following edge: add in EX.
//   3. rt=0 and flush priority: lw rt=0 with ID rs=0 -> no stall. Separately,
//      flush=1 together with a hazard -> bubble, id_stall=0, bubble_cnt unchanged.
//   4. Flush during ex_stall: ex_stall=1 for 3 cycles, 1-cycle flush in cycle 2
//      -> EX held throughout. First edge after release loads a bubble;
//      pend_flush=0 after that edge.
//   5. Async reset mid-stall: assert rst between edges while ex_valid=1 and
//      bubble_cnt=7 -> ex_valid, ex_ctrl and bubble_cnt read 0 before the next
//      edge.
//   6. Saturation with CNT_W=2: five back-to-back load-use hazards ->
//      bubble_cnt=3.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the MIPS core pipeline: the width of the decoded
//   control bundle, the bit position of every field inside it, and the
//   register-zero specifier.
//   Bundle packing (MSB..LSB):
//     {RegDst[1:0], Jmp[1:0], DataC, Regwrite, AluSrc, Branch,
//      MemRead, MemWrite, MemtoReg, AluOperation[2:0]}
package cpu_pkg;

  localparam int CTRL_W = 14;

  localparam int CTRL_REGDST_HI = 13;
  localparam int CTRL_REGDST_LO = 12;
  localparam int CTRL_JMP_HI    = 11;
  localparam int CTRL_JMP_LO    = 10;
  localparam int CTRL_DATAC     = 9;
  localparam int CTRL_REGWRITE  = 8;
  localparam int CTRL_ALUSRC    = 7;
  localparam int CTRL_BRANCH    = 6;
  localparam int CTRL_MEMREAD   = 5;
  localparam int CTRL_MEMWRITE  = 4;
  localparam int CTRL_MEMTOREG  = 3;
  localparam int CTRL_ALUOP_HI  = 2;
  localparam int CTRL_ALUOP_LO  = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/lu_hazard_detect.sv
// lu_hazard_detect
//   Combinational load-use hazard detector. Flags the case where the
//   instruction in EX is a load whose destination (rt) is read by the
//   instruction currently in ID.
// Ports
//   ex_valid    in   EX slot holds a real instruction
//   ex_memread  in   MemRead bit of the EX control bundle
//   ex_rt       in   rt specifier of the EX instruction (load destination)
//   id_valid    in   ID slot holds a real instruction
//   id_rs       in   rs specifier of the ID instruction
//   id_rt       in   rt specifier of the ID instruction
//   lu_hazard   out  ID must wait one cycle for the load result
module lu_hazard_detect
  import cpu_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       lu_hazard
);

  // A load into $zero never produces a usable value, so it can never
  // create a dependency.
  always_comb begin
    lu_hazard = ex_valid & ex_memread & id_valid &
                (ex_rt != REG_ZERO) &
                ((ex_rt == id_rs) | (ex_rt == id_rt));
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Decode-to-execute pipeline register. Captures the control bundle,
//   operands and register specifiers from ID every cycle, inserts a single
//   bubble on a load-use hazard, honours branch/jump flushes (remembering a
//   flush that arrives while EX is stalled) and counts load-use bubbles in a
//   saturating counter.
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   id_valid, id_ctrl           ID instruction valid flag and control bundle
//   id_pc4, id_rd1, id_rd2,
//   id_imm                      ID operands (DATA_W each)
//   id_rs, id_rt, id_rd         ID register specifiers
//   flush                       taken branch/jump in EX; kill ID instruction
//   ex_stall                    EX/MEM not ready; hold the EX register
//   id_stall                    combinational hold request for IF/ID and PC
//   ex_valid, ex_ctrl, ex_pc4,
//   ex_rd1, ex_rd2, ex_imm,
//   ex_rs, ex_rt, ex_rd         registered EX copies of the ID fields
//   bubble_cnt                  saturating load-use bubble count (CNT_W)
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic lu_hazard;
  logic pend_flush;

  lu_hazard_detect u_lu_hazard_detect (
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl[CTRL_MEMREAD]),
    .ex_rt      (ex_rt),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .lu_hazard  (lu_hazard)
  );

  // A hazard only holds ID when the ID instruction survives; a flush (live
  // or pending) kills it anyway, so there is nothing to wait for.
  always_comb begin
    id_stall = ex_stall | (lu_hazard & ~flush & ~pend_flush);
  end

  // Priority: stall holds everything, then flush, then hazard bubble, then
  // a normal load. A bubble zeroes the whole slot so no write, store,
  // branch or jump can leak downstream. A flush seen during a stall is
  // latched in pend_flush and applied on the first non-stalled edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      pend_flush <= 1'b0;
      bubble_cnt <= '0;
    end else if (ex_stall) begin
      pend_flush <= pend_flush | flush;
    end else if (flush | pend_flush | lu_hazard) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rd1     <= '0;
      ex_rd2     <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      pend_flush <= 1'b0;
      // Only genuine load-use bubbles are counted, never flush bubbles.
      if (!(flush | pend_flush) && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
    end else begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : '0;
      ex_pc4   <= id_pc4;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage
//   Directed self-checking bench for id_ex_stage. A second instance with a
//   2-bit bubble counter shares the same stimulus to exercise saturation.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam logic [CTRL_W-1:0] C_ADDI = 14'h0182; // Regwrite, AluSrc, AluOp=010
  localparam logic [CTRL_W-1:0] C_LW   = 14'h01AA; // + MemRead, MemtoReg
  localparam logic [CTRL_W-1:0] C_ADD  = 14'h1102; // RegDst=01, Regwrite, AluOp=010

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [31:0]       id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic              flush, ex_stall;

  logic              id_stall, ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [31:0]       ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [15:0]       bubble_cnt;

  logic              s_id_stall, s_ex_valid;
  logic [CTRL_W-1:0] s_ex_ctrl;
  logic [31:0]       s_ex_pc4, s_ex_rd1, s_ex_rd2, s_ex_imm;
  logic [4:0]        s_ex_rs, s_ex_rt, s_ex_rd;
  logic [1:0]        s_bubble_cnt;

  int vectors;
  int miscompares;

  id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_stall(ex_stall), .id_stall(id_stall), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
    .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .flush(flush),
    .ex_stall(ex_stall), .id_stall(s_id_stall), .ex_valid(s_ex_valid),
    .ex_ctrl(s_ex_ctrl), .ex_pc4(s_ex_pc4), .ex_rd1(s_ex_rd1), .ex_rd2(s_ex_rd2),
    .ex_imm(s_ex_imm), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
    .bubble_cnt(s_bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive a full ID slot; pc4/rd2 are derived so every field carries data.
  task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                               input logic [31:0] rd1, input logic [31:0] imm,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd);
    id_valid = v;
    id_ctrl  = c;
    id_pc4   = 32'h0000_0100 + rd1;
    id_rd1   = rd1;
    id_rd2   = rd1 + 32'd1;
    id_imm   = imm;
    id_rs    = rs;
    id_rt    = rt;
    id_rd    = rd;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    flush       = 1'b0;
    ex_stall    = 1'b0;
    applyStimulus(1'b0, '0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);

    // Reset state
    #12;
    checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("rst_ex_ctrl", {18'd0, ex_ctrl}, 32'd0);
    checkOutput("rst_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
    checkOutput("rst_id_stall_lo", {31'd0, id_stall}, 32'd0);
    ex_stall = 1'b1;
    #1;
    checkOutput("rst_id_stall_hi", {31'd0, id_stall}, 32'd1);
    ex_stall = 1'b0;
    #1;
    rst = 1'b0;

    // 1. Normal addi load
    applyStimulus(1'b1, C_ADDI, 32'd5, 32'd3, 5'd1, 5'd2, 5'd0);
    step();
    checkOutput("t1_ex_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("t1_ex_ctrl", {18'd0, ex_ctrl}, {18'd0, C_ADDI});
    checkOutput("t1_ex_rd1", ex_rd1, 32'd5);
    checkOutput("t1_ex_imm", ex_imm, 32'd3);
    checkOutput("t1_ex_pc4", ex_pc4, 32'h105);
    checkOutput("t1_id_stall", {31'd0, id_stall}, 32'd0);

    // 2. Load-use: lw rt=8 in EX, add rs=8 in ID
    applyStimulus(1'b1, C_LW, 32'd9, 32'd0, 5'd9, 5'd8, 5'd0);
    step();
    applyStimulus(1'b1, C_ADD, 32'd20, 32'd0, 5'd8, 5'd10, 5'd11);
    #1;
    checkOutput("t2_id_stall", {31'd0, id_stall}, 32'd1);
    step();
    checkOutput("t2_bub_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("t2_bub_ctrl", {18'd0, ex_ctrl}, 32'd0);
    checkOutput("t2_bub_rd1", ex_rd1, 32'd0);
    checkOutput("t2_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
    checkOutput("t2_id_stall_clr", {31'd0, id_stall}, 32'd0);
    step();
    checkOutput("t2_add_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("t2_add_ctrl", {18'd0, ex_ctrl}, {18'd0, C_ADD});
    checkOutput("t2_add_rs", {27'd0, ex_rs}, 32'd8);
    checkOutput("t2_add_rd", {27'd0, ex_rd}, 32'd11);

    // 3a. lw into $zero never stalls
    applyStimulus(1'b1, C_LW, 32'd1, 32'd0, 5'd3, 5'd0, 5'd0);
    step();
    applyStimulus(1'b1, C_ADD, 32'd2, 32'd0, 5'd0, 5'd0, 5'd4);
    #1;
    checkOutput("t3_zero_stall", {31'd0, id_stall}, 32'd0);
    step();
    checkOutput("t3_zero_ctrl", {18'd0, ex_ctrl}, {18'd0, C_ADD});
    checkOutput("t3_zero_cnt", {16'd0, bubble_cnt}, 32'd1);

    // 3b. flush beats hazard
    applyStimulus(1'b1, C_LW, 32'd1, 32'd0, 5'd3, 5'd8, 5'd0);
    step();
    applyStimulus(1'b1, C_ADD, 32'd2, 32'd0, 5'd8, 5'd1, 5'd4);
    flush = 1'b1;
    #1;
    checkOutput("t3_flush_stall", {31'd0, id_stall}, 32'd0);
    step();
    flush = 1'b0;
    checkOutput("t3_flush_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("t3_flush_ctrl", {18'd0, ex_ctrl}, 32'd0);
    checkOutput("t3_flush_cnt", {16'd0, bubble_cnt}, 32'd1);
    step();
    checkOutput("t3_post_ctrl", {18'd0, ex_ctrl}, {18'd0, C_ADD});

    // 4. Flush during a 3-cycle ex_stall
    applyStimulus(1'b1, C_ADDI, 32'h77, 32'd1, 5'd5, 5'd6, 5'd0);
    ex_stall = 1'b1;
    #1;
    checkOutput("t4_id_stall", {31'd0, id_stall}, 32'd1);
    step();
    checkOutput("t4_hold1_ctrl", {18'd0, ex_ctrl}, {18'd0, C_ADD});
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("t4_hold2_ctrl", {18'd0, ex_ctrl}, {18'd0, C_ADD});
    checkOutput("t4_hold2_rs", {27'd0, ex_rs}, 32'd8);
    step();
    checkOutput("t4_hold3_valid", {31'd0, ex_valid}, 32'd1);
    ex_stall = 1'b0;
    step();
    checkOutput("t4_bub_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("t4_bub_ctrl", {18'd0, ex_ctrl}, 32'd0);
    step();
    checkOutput("t4_load_rd1", ex_rd1, 32'h77);
    checkOutput("t4_load_valid", {31'd0, ex_valid}, 32'd1);
    checkOutput("t4_cnt", {16'd0, bubble_cnt}, 32'd1);

    // 5. Bring counter to 7, then reset mid-stall
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, C_LW, 32'd1, 32'd0, 5'd3, 5'd8, 5'd0);
      step();
      applyStimulus(1'b1, C_ADD, 32'd2, 32'd0, 5'd8, 5'd1, 5'd4);
      step();
    end
    checkOutput("t5_cnt7", {16'd0, bubble_cnt}, 32'd7);
    applyStimulus(1'b1, C_LW, 32'd1, 32'd0, 5'd3, 5'd8, 5'd0);
    step();
    ex_stall = 1'b1;
    step();
    checkOutput("t5_pre_valid", {31'd0, ex_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", {31'd0, ex_valid}, 32'd0);
    checkOutput("t5_rst_ctrl", {18'd0, ex_ctrl}, 32'd0);
    checkOutput("t5_rst_cnt", {16'd0, bubble_cnt}, 32'd0);
    #1;
    rst = 1'b0;
    ex_stall = 1'b0;

    // 6. Five load-use hazards: 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, C_LW, 32'd1, 32'd0, 5'd3, 5'd8, 5'd0);
      step();
      applyStimulus(1'b1, C_ADD, 32'd2, 32'd0, 5'd1, 5'd8, 5'd4);
      step();
    end
    checkOutput("t6_sat_cnt", {30'd0, s_bubble_cnt}, 32'd3);
    checkOutput("t6_wide_cnt", {16'd0, bubble_cnt}, 32'd5);
    checkOutput("t6_sat_valid", {31'd0, s_ex_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
